// File: rtl/ifsram_wr_mb.sv
// Ifmap SRAM write generator: drains a FWFT FIFO into NUM_BANK SRAM banks, round-robin by row.
// Define IFSRAM_WR_PAD_EN to frame every row with one leading and one trailing zero word.
module ifsram_wr_mb #(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned ADDR_W   = 11,
  parameter int unsigned NUM_BANK = 3,
  parameter int unsigned WCNT_W   = 10,
  parameter int unsigned RCNT_W   = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [WCNT_W-1:0]   cfg_row_words,
  input  logic [RCNT_W-1:0]   cfg_rows,
  output logic                busy,
  output logic                done,
  input  logic [DATA_W-1:0]   fifo_data,
  input  logic                fifo_empty_n,
  output logic                fifo_read,
  output logic [NUM_BANK-1:0] sram_cen,
  output logic [NUM_BANK-1:0] sram_wen,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [DATA_W-1:0]   sram_data
);

  localparam int unsigned BankW = (NUM_BANK > 1) ? $clog2(NUM_BANK) : 1;
  // One extra bit so row_words+2 fits when rows are padded.
  localparam int unsigned ColW  = WCNT_W + 1;
  localparam logic [BankW-1:0] LastBank = BankW'(NUM_BANK - 1);
`ifdef IFSRAM_WR_PAD_EN
  localparam logic [ColW-1:0] PadWords = ColW'(2);
`else
  localparam logic [ColW-1:0] PadWords = '0;
`endif

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e              state_q, state_d;
  logic [WCNT_W-1:0]   row_words_q, row_words_d;
  logic [RCNT_W-1:0]   rows_q, rows_d;
  logic [ColW-1:0]     col_q, col_d;
  logic [RCNT_W-1:0]   row_q, row_d;
  logic [BankW-1:0]    bank_q, bank_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [NUM_BANK-1:0] cen_q, cen_d;
  logic [NUM_BANK-1:0] wen_q, wen_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;

  logic [ColW-1:0]     row_len;
  logic                col_last;
  logic                row_last;
  logic                is_pad;
  logic                run;
  logic                step;
  logic [NUM_BANK-1:0] bank_dec;

  assign row_len  = ColW'(row_words_q) + PadWords;
  assign col_last = (col_q == row_len - 1'b1);
  assign row_last = (row_q == rows_q - 1'b1);
  assign run      = (state_q == StRun);

`ifdef IFSRAM_WR_PAD_EN
  assign is_pad = (col_q == '0) || col_last;
`else
  assign is_pad = 1'b0;
`endif

  // Pad slots advance unconditionally; data slots need a word from the FIFO.
  assign step      = run & (is_pad | fifo_empty_n);
  assign fifo_read = run & ~reset & ~is_pad & fifo_empty_n;

  assign busy      = run;
  assign done      = (state_q == StDone);
  assign sram_cen  = cen_q;
  assign sram_wen  = wen_q;
  assign sram_addr = addr_q;
  assign sram_data = data_q;

  always_comb begin
    bank_dec = '0;
    for (int unsigned i = 0; i < NUM_BANK; i++) begin
      bank_dec[i] = (bank_q == BankW'(i));
    end
  end

  always_comb begin
    state_d     = state_q;
    row_words_d = row_words_q;
    rows_d      = rows_q;
    col_d       = col_q;
    row_d       = row_q;
    bank_d      = bank_q;
    base_d      = base_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          row_words_d = cfg_row_words;
          rows_d      = cfg_rows;
          col_d       = '0;
          row_d       = '0;
          bank_d      = '0;
          base_d      = '0;
          state_d     = ((cfg_rows == '0) || (cfg_row_words == '0)) ? StDone : StRun;
        end
      end
      StRun: begin
        if (step) begin
          if (col_last) begin
            col_d = '0;
            row_d = row_q + 1'b1;
            if (bank_q == LastBank) begin
              bank_d = '0;
              base_d = base_q + ADDR_W'(row_len);
            end else begin
              bank_d = bank_q + 1'b1;
            end
            if (row_last) begin
              state_d = StDone;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Write port is registered one cycle behind the accepted word; addr/data hold when idle.
  always_comb begin
    cen_d  = '1;
    wen_d  = '1;
    addr_d = addr_q;
    data_d = data_q;
    if (step) begin
      cen_d  = ~bank_dec;
      wen_d  = ~bank_dec;
      addr_d = base_q + ADDR_W'(col_q);
      data_d = is_pad ? '0 : fifo_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      row_words_q <= '0;
      rows_q      <= '0;
      col_q       <= '0;
      row_q       <= '0;
      bank_q      <= '0;
      base_q      <= '0;
      cen_q       <= '1;
      wen_q       <= '1;
      addr_q      <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      row_words_q <= row_words_d;
      rows_q      <= rows_d;
      col_q       <= col_d;
      row_q       <= row_d;
      bank_q      <= bank_d;
      base_q      <= base_d;
      cen_q       <= cen_d;
      wen_q       <= wen_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
    end
  end

endmodule

// File: tb/tb_ifsram_wr_mb.sv
// Self-checking bench for ifsram_wr_mb: table-driven runs, randomized FIFO stalls and a
// reset-abort sequence, all checked against a row/bank/address model built from plain arithmetic.
module tb_ifsram_wr_mb;

  localparam int DW = 64;
  localparam int AW = 11;
  localparam int NB = 3;
  localparam int WW = 10;
  localparam int RW = 8;
`ifdef IFSRAM_WR_PAD_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [WW-1:0] cfg_row_words;
  logic [RW-1:0] cfg_rows;
  logic          busy;
  logic          done;
  logic [DW-1:0] fifo_data;
  logic          fifo_empty_n;
  logic          fifo_read;
  logic [NB-1:0] sram_cen;
  logic [NB-1:0] sram_wen;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_data;

  ifsram_wr_mb #(
    .DATA_W  (DW),
    .ADDR_W  (AW),
    .NUM_BANK(NB),
    .WCNT_W  (WW),
    .RCNT_W  (RW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .cfg_row_words(cfg_row_words),
    .cfg_rows     (cfg_rows),
    .busy         (busy),
    .done         (done),
    .fifo_data    (fifo_data),
    .fifo_empty_n (fifo_empty_n),
    .fifo_read    (fifo_read),
    .sram_cen     (sram_cen),
    .sram_wen     (sram_wen),
    .sram_addr    (sram_addr),
    .sram_data    (sram_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int w;
    int r;
    int mode;      // 0: FIFO always full, 1: toggling, 2: random stalls
    bit restart;   // pulse start with other cfg mid-run
    int exp_pops;
  } vec_t;

  int tests = 0;
  int fails = 0;

  logic [31:0] seed;
  int pops, busy_cnt, done_cnt, done_cyc, done_nowr, viol, cyc, head;
  int wb[$];
  int wa[$];
  logic [DW-1:0] wd[$];
  int eb[$];
  int ea[$];
  logic [DW-1:0] ed[$];

  function automatic void check(string name, logic [127:0] got, logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endfunction

  function automatic logic [DW-1:0] data_of(int k);
    return {seed ^ 32'(k), 32'(k) * 32'h9e3779b1};
  endfunction

  task automatic clear_stats();
    pops = 0; busy_cnt = 0; done_cnt = 0; done_cyc = -1; done_nowr = 0; viol = 0; cyc = 0;
    wb.delete(); wa.delete(); wd.delete();
  endtask

  // Sample on the falling edge, then update the FIFO model just after the rising edge.
  task automatic tick(input int mode);
    bit popped;
    @(negedge clk);
    if (busy) busy_cnt++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      if (sram_cen == '1) done_nowr++;
    end
    if (fifo_read && !fifo_empty_n) viol++;
    if (sram_cen !== sram_wen) viol++;
    if ($countones(~sram_cen) > 1) viol++;
    popped = fifo_read & fifo_empty_n;
    if (popped) pops++;
    for (int b = 0; b < NB; b++) begin
      if (sram_cen[b] == 1'b0) begin
        wb.push_back(b);
        wa.push_back(int'(sram_addr));
        wd.push_back(sram_data);
      end
    end
    @(posedge clk);
    #1;
    if (popped) head++;
    cyc++;
    case (mode)
      0:       fifo_empty_n = 1'b1;
      1:       fifo_empty_n = ~fifo_empty_n;
      default: fifo_empty_n = ($urandom_range(0, 3) != 0);
    endcase
    fifo_data = fifo_empty_n ? data_of(head) : {$urandom, $urandom};
  endtask

  task automatic run_cfg(input int w, input int r, input int mode, input bit restart,
                         input int exp_pops, input string name);
    int k;
    int first_bad;
    int exp_busy;
    bit pad;
    logic [127:0] act_p;
    logic [127:0] exp_p;
    seed = $urandom;
    head = 0;
    clear_stats();
    fifo_empty_n  = 1'b1;
    fifo_data     = data_of(0);
    start         = 1'b1;
    cfg_row_words = WW'(w);
    cfg_rows      = RW'(r);
    tick(mode);
    start = 1'b0;
    while (done_cnt == 0 && cyc < 20000) begin
      start = restart && (cyc == 5);
      if (start) begin
        cfg_row_words = WW'(w + 1);
        cfg_rows      = RW'(2);
      end
      tick(mode);
    end
    start = 1'b0;
    tick(mode);
    tick(mode);

    // Reference: row rr goes to bank rr%NB at base (rr/NB)*row_len, data in FIFO order.
    eb.delete(); ea.delete(); ed.delete();
    k = 0;
    if (w > 0 && r > 0) begin
      for (int rr = 0; rr < r; rr++) begin
        for (int c = 0; c < w + 2 * P; c++) begin
          pad = (P == 1) && (c == 0 || c == w + 1);
          eb.push_back(rr % NB);
          ea.push_back(((rr / NB) * (w + 2 * P) + c) % (1 << AW));
          ed.push_back(pad ? '0 : data_of(k));
          if (!pad) k++;
        end
      end
    end
    exp_busy = (exp_pops == 0) ? 0 : exp_pops + 2 * r * P;

    check({name, " pops"}, pops, k);
    check({name, " table pops"}, pops, exp_pops);
    check({name, " write count"}, wb.size(), eb.size());
    check({name, " done pulses"}, done_cnt, 1);
    check({name, " done timing"}, done_cyc, busy_cnt + 1);
    check({name, " protocol"}, viol, 0);
    if (exp_pops > 0) check({name, " done w/o write"}, done_nowr, 0);
    if (mode == 0) check({name, " busy cycles"}, busy_cnt, exp_busy);
    first_bad = -1;
    for (int i = 0; i < wb.size() && i < eb.size(); i++) begin
      if (wb[i] != eb[i] || wa[i] != ea[i] || wd[i] !== ed[i]) begin
        first_bad = i;
        break;
      end
    end
    if (first_bad >= 0) begin
      act_p = {51'd0, 2'(wb[first_bad]), 11'(wa[first_bad]), wd[first_bad]};
      exp_p = {51'd0, 2'(eb[first_bad]), 11'(ea[first_bad]), ed[first_bad]};
      check($sformatf("%s write#%0d {bank,addr,data}", name, first_bad), act_p, exp_p);
    end else begin
      check({name, " write seq"}, (wb.size() < eb.size()) ? wb.size() : eb.size(), eb.size());
    end
  endtask

  initial begin
    vec_t vt[8];
    reset         = 1'b1;
    start         = 1'b0;
    cfg_row_words = '0;
    cfg_rows      = '0;
    fifo_empty_n  = 1'b0;
    fifo_data     = '0;
    seed          = $urandom;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset fifo_read", fifo_read, 0);
    check("reset cen", sram_cen, 3'b111);
    check("reset wen", sram_wen, 3'b111);
    check("reset addr", sram_addr, 0);
    check("reset data", sram_data, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    vt[0] = '{w: 4,    r: 6, mode: 0, restart: 1'b0, exp_pops: 24};
    vt[1] = '{w: 4,    r: 6, mode: 1, restart: 1'b0, exp_pops: 24};
    vt[2] = '{w: 4,    r: 0, mode: 0, restart: 1'b0, exp_pops: 0};
    vt[3] = '{w: 0,    r: 3, mode: 0, restart: 1'b0, exp_pops: 0};
    vt[4] = '{w: 4,    r: 6, mode: 0, restart: 1'b1, exp_pops: 24};
    vt[5] = '{w: 2,    r: 1, mode: 0, restart: 1'b0, exp_pops: 2};
    vt[6] = '{w: 1,    r: 7, mode: 2, restart: 1'b0, exp_pops: 7};
    vt[7] = '{w: 1000, r: 7, mode: 0, restart: 1'b0, exp_pops: 7000};
    for (int i = 0; i < 8; i++) begin
      run_cfg(vt[i].w, vt[i].r, vt[i].mode, vt[i].restart, vt[i].exp_pops,
              $sformatf("vec%0d", i));
    end

    // Reset after 10 accepted words aborts the run; a new start begins from scratch.
    seed = $urandom;
    head = 0;
    clear_stats();
    fifo_empty_n  = 1'b1;
    fifo_data     = data_of(0);
    start         = 1'b1;
    cfg_row_words = WW'(4);
    cfg_rows      = RW'(6);
    tick(0);
    start = 1'b0;
    while (pops < 10 && cyc < 100) tick(0);
    check("abort pops before reset", pops, 10);
    reset = 1'b1;
    @(negedge clk);
    check("abort no pop in reset", fifo_read, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort cen", sram_cen, 3'b111);
    check("abort wen", sram_wen, 3'b111);
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort fifo_read", fifo_read, 0);
    clear_stats();
    repeat (3) tick(0);
    check("abort quiet done", done_cnt, 0);
    check("abort quiet writes", wb.size(), 0);
    check("abort quiet pops", pops, 0);
    run_cfg(4, 6, 0, 1'b0, 24, "after_abort");

    for (int i = 0; i < 4; i++) begin
      int w;
      int r;
      w = $urandom_range(1, 6);
      r = $urandom_range(1, 9);
      run_cfg(w, r, 2, 1'b0, w * r, $sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
